decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage: decodes RV32I-style instruction words into a small circular FIFO.
// Optional macro DECODE_RV64_W_EN adds the RV64 OP-IMM-32 / OP-32 word opcodes.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_type,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_SB = 3'd3,
                         T_UJ = 3'd4, T_U = 3'd5, T_NONE = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011, OP_IMM   = 7'b0010011,
                         OP_JALR   = 7'b1100111, OP_SYSTEM = 7'b1110011,
                         OP_REG    = 7'b0110011, OP_STORE = 7'b0100011,
                         OP_BRANCH = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_IMM32  = 7'b0011011, OP_REG32 = 7'b0111011;

  typedef struct packed {
    logic [2:0]      typ;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            br;
    logic            jmp;
    logic            ill;
  } entry_t;

  entry_t        dec;
  logic [31:0]   imm32;
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, valid_q;
  logic          push, pop;

  always_comb begin
    dec     = '0;
    imm32   = '0;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    dec.f3  = in_instr[14:12];
    dec.f7  = in_instr[31:25];
    dec.pc  = in_pc;
    dec.typ = T_NONE;
    case (in_instr[6:0])
      OP_LOAD:              begin dec.typ = T_I;  dec.rw = 1'b1; dec.mr = 1'b1; end
      OP_IMM, OP_SYSTEM:    begin dec.typ = T_I;  dec.rw = 1'b1; end
      OP_JALR:              begin dec.typ = T_I;  dec.rw = 1'b1; dec.jmp = 1'b1; end
      OP_REG:               begin dec.typ = T_R;  dec.rw = 1'b1; end
      OP_STORE:             begin dec.typ = T_S;  dec.mw = 1'b1; end
      OP_BRANCH:            begin dec.typ = T_SB; dec.br = 1'b1; end
      OP_JAL:               begin dec.typ = T_UJ; dec.rw = 1'b1; dec.jmp = 1'b1; end
      OP_LUI, OP_AUIPC:     begin dec.typ = T_U;  dec.rw = 1'b1; end
`ifdef DECODE_RV64_W_EN
      OP_IMM32:             begin dec.typ = T_I;  dec.rw = 1'b1; end
      OP_REG32:             begin dec.typ = T_R;  dec.rw = 1'b1; end
`endif
      default:              dec.ill = 1'b1;
    endcase

    // Every legal opcode ends in 2'b11; this catches compressed encodings explicitly.
    if (in_instr[1:0] != 2'b11) dec.ill = 1'b1;

    case (dec.typ)
      T_I:     imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      T_S:     imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      T_SB:    imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      T_UJ:    imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      T_U:     imm32 = {in_instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase

    if (dec.ill) begin
      dec.typ = T_NONE;
      dec.rw  = 1'b0;
      dec.mr  = 1'b0;
      dec.mw  = 1'b0;
      dec.br  = 1'b0;
      dec.jmp = 1'b0;
      imm32   = '0;
    end
    dec.imm = XLEN'($signed(imm32));
  end

  assign push = in_valid  & ready_q;
  assign pop  = out_ready & valid_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Ready/valid are registered copies of the next count, so out_ready never reaches in_ready.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      ready_q <= (count_d < (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem_q[wr_ptr_q] <= dec;
  end

  entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign in_ready      = ready_q;
  assign out_valid     = valid_q;
  assign out_type      = head.typ;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_funct3    = head.f3;
  assign out_funct7    = head.f7;
  assign out_imm       = head.imm;
  assign out_pc        = head.pc;
  assign out_reg_write = head.rw;
  assign out_mem_read  = head.mr;
  assign out_mem_write = head.mw;
  assign out_branch    = head.br;
  assign out_jump      = head.jmp;
  assign out_illegal   = head.ill;

endmodule
